// File: rtl/pipeline_interlock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_interlock_ctrl
//  Purpose  : Stall/flush sequencer for the 5-stage pipeline (IF, OF, EX, MA,
//             RW). It covers the hazards forwarding cannot hide: load-use,
//             multi-cycle mul/div/mod in EX, and taken branches. It drives
//             the PC hold, pipeline-register holds and bubble injections, and
//             keeps saturating stall/flush counters for performance debug.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MD_LATENCY  EX cycles for mul/div/mod (1..5); stall = MD_LATENCY-1 cycles
//    CNT_W       width of the performance counters
//  Ports
//    clk              in   1      pipeline clock, rising edge
//    reset            in   1      asynchronous active-high reset
//    input_OF_IR      in   32     instruction in OF stage
//    input_EX_IR      in   32     instruction in EX stage
//    is_branch_taken  in   1      EX-stage branch resolved taken
//    stall_pc         out  1      hold PC
//    stall_if_of      out  1      hold IF/OF register
//    hold_of_ex       out  1      hold OF/EX register
//    bubble_of_ex     out  1      load nop into OF/EX register
//    bubble_ex_ma     out  1      load nop into EX/MA register
//    flush_if_of      out  1      load nop into IF/OF register
//    stall_cycle_cnt  out  CNT_W  saturating count of stall_pc cycles
//    flush_cnt        out  CNT_W  saturating count of flush_if_of cycles
// ============================================================================
module pipeline_interlock_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      input_OF_IR,
  input  logic [31:0]      input_EX_IR,
  input  logic             is_branch_taken,
  output logic             stall_pc,
  output logic             stall_if_of,
  output logic             hold_of_ex,
  output logic             bubble_of_ex,
  output logic             bubble_ex_ma,
  output logic             flush_if_of,
  output logic [CNT_W-1:0] stall_cycle_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Opcodes
  localparam logic [4:0] c_OP_MUL  = 5'b00010;
  localparam logic [4:0] c_OP_DIV  = 5'b00011;
  localparam logic [4:0] c_OP_MOD  = 5'b00100;
  localparam logic [4:0] c_OP_NOT  = 5'b01000;
  localparam logic [4:0] c_OP_MOV  = 5'b01001;
  localparam logic [4:0] c_OP_NOP  = 5'b01101;
  localparam logic [4:0] c_OP_LD   = 5'b01110;
  localparam logic [4:0] c_OP_ST   = 5'b01111;
  localparam logic [4:0] c_OP_BEQ  = 5'b10000;
  localparam logic [4:0] c_OP_BGT  = 5'b10001;
  localparam logic [4:0] c_OP_B    = 5'b10010;
  localparam logic [4:0] c_OP_CALL = 5'b10011;
  localparam logic [4:0] c_OP_RET  = 5'b10100;
  localparam logic [3:0] c_REG_RA  = 4'b1111;

  // With a single-cycle multiplier the mul/div trigger is compiled out.
  localparam logic       c_MD_EN       = (MD_LATENCY > 1);
  localparam logic       c_MD_SKIP     = (MD_LATENCY == 2);
  localparam int         c_MD_LOAD_INT = (MD_LATENCY >= 2) ? (MD_LATENCY - 2) : 0;
  localparam logic [1:0] c_MD_LOAD     = c_MD_LOAD_INT[1:0];

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // --------------------------------------------------------------------------
  // Instruction field decode
  // --------------------------------------------------------------------------
  logic [4:0] w_of_op;
  logic       w_of_imm;
  logic [3:0] w_of_rd;
  logic [3:0] w_of_rs1;
  logic [3:0] w_of_rs2;
  logic [4:0] w_ex_op;
  logic [3:0] w_ex_rd;
  logic       w_unused_bits;

  assign w_of_op  = input_OF_IR[31:27];
  assign w_of_imm = input_OF_IR[26];
  assign w_of_rd  = input_OF_IR[25:22];
  assign w_of_rs1 = input_OF_IR[21:18];
  assign w_of_rs2 = input_OF_IR[17:14];
  assign w_ex_op  = input_EX_IR[31:27];
  assign w_ex_rd  = input_EX_IR[25:22];

  assign w_unused_bits = ^{input_OF_IR[13:0], input_EX_IR[26], input_EX_IR[21:0]};

  // --------------------------------------------------------------------------
  // Which registers the OF instruction actually reads
  // --------------------------------------------------------------------------
  logic w_of_no_regs;  // control-flow/nop: neither rs1 nor rs2
  logic w_of_rs1_used;
  logic w_of_rs2_used;
  logic w_of_rd_used;  // store data comes from rd
  logic w_of_ra_used;  // ret reads the link register

  assign w_of_no_regs  = (w_of_op == c_OP_NOP) || (w_of_op == c_OP_B)   ||
                         (w_of_op == c_OP_BEQ) || (w_of_op == c_OP_BGT) ||
                         (w_of_op == c_OP_CALL)|| (w_of_op == c_OP_RET);
  assign w_of_rs1_used = !(w_of_no_regs || (w_of_op == c_OP_NOT) || (w_of_op == c_OP_MOV));
  assign w_of_rs2_used = !w_of_imm && !w_of_no_regs;
  assign w_of_rd_used  = (w_of_op == c_OP_ST);
  assign w_of_ra_used  = (w_of_op == c_OP_RET);

  logic w_ex_is_md;
  logic w_load_use;

  assign w_ex_is_md = (w_ex_op == c_OP_MUL) || (w_ex_op == c_OP_DIV) || (w_ex_op == c_OP_MOD);
  assign w_load_use = (w_ex_op == c_OP_LD) &&
                      ((w_of_rs1_used && (w_of_rs1 == w_ex_rd)) ||
                       (w_of_rs2_used && (w_of_rs2 == w_ex_rd)) ||
                       (w_of_rd_used  && (w_of_rd  == w_ex_rd)) ||
                       (w_of_ra_used  && (c_REG_RA == w_ex_rd)));

  // --------------------------------------------------------------------------
  // Hazard selection. EX holds a single instruction, so the sources are
  // exclusive; the priority order only matters for malformed inputs.
  // --------------------------------------------------------------------------
  logic w_md_stall;
  logic w_br_flush;
  logic w_ld_stall;

  always_comb begin
    w_md_stall = 1'b0;
    w_br_flush = 1'b0;
    w_ld_stall = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (c_MD_EN && w_ex_is_md) begin
          w_md_stall = 1'b1;
        end else if (is_branch_taken) begin
          w_br_flush = 1'b1;
        end else if (w_load_use) begin
          w_ld_stall = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        // Branch resolution is meaningless while EX is still computing.
        w_md_stall = 1'b1;
      end
      ST_MD_DONE: begin
        // The finished mul/div is still in EX this cycle; do not retrigger.
        if (is_branch_taken) begin
          w_br_flush = 1'b1;
        end else if (w_load_use) begin
          w_ld_stall = 1'b1;
        end
      end
      default: begin
        w_md_stall = 1'b0;
      end
    endcase
  end

  // Outputs are gated by reset so they drop in the same cycle reset rises.
  logic w_stall;
  assign w_stall = !reset && (w_md_stall || w_ld_stall);

  assign stall_pc        = w_stall;
  assign stall_if_of     = w_stall;
  assign hold_of_ex      = !reset && w_md_stall;
  assign bubble_ex_ma    = !reset && w_md_stall;
  assign bubble_of_ex    = !reset && (w_br_flush || w_ld_stall);
  assign flush_if_of     = !reset && w_br_flush;
  assign stall_cycle_cnt = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;

  // --------------------------------------------------------------------------
  // Multi-cycle sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_md_cnt <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (c_MD_EN && w_ex_is_md) begin
            r_md_cnt <= c_MD_LOAD;
            r_state  <= c_MD_SKIP ? ST_MD_DONE : ST_MD_BUSY;
          end
        end
        ST_MD_BUSY: begin
          r_md_cnt <= r_md_cnt - 2'd1;
          // <=1 also recovers from an out-of-range zero count.
          if (r_md_cnt <= 2'd1) begin
            r_state <= ST_MD_DONE;
          end
        end
        ST_MD_DONE: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_if_of && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
